dt_ff_excitation_gen: RTL and testbench
=======================================

Name: dt_ff_excitation_gen

Overview:
- Inverse companion to the dual-mode load/toggle flip-flop: it converts a stream of target state bits into the flop's control pair (b1 = data/toggle, b2 = mode select: 1 = load, 0 = toggle/hold).
- Holds a behavioural model of the flop state and checks the flop's slave output (fed back as q_fb) against the expected value after every drive.
- Sits between a target-bit producer (valid/ready) and one instance of the flop.

Parameters:
- DEPTH, 4, target FIFO entries; power of two, at least 2.
- MODE_POLICY, 0, 0 = always drive load mode; 1 = always drive toggle mode.
- CNT_W, 8, width of the mismatch counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tgt_valid  input  1  producer has a target bit.
- tgt_bit  input  1  desired flop state.
- tgt_ready  output  1  FIFO can accept; equals !full.
- b1  output  1  registered flop control, data or toggle input.
- b2  output  1  registered flop control, mode select.
- drv_valid  output  1  b1/b2 carry a real command this cycle.
- q_fb  input  1  flop slave output (Q1), settled before the next rising edge.
- busy  output  1  FIFO non-empty or FSM not in IDLE.
- model_q  output  1  current modelled flop state.
- err  output  1  sticky mismatch flag.
- err_cnt  output  CNT_W  saturating count of mismatches.

Behaviour:
- Reset (async, rst_n = 0):
  - FIFO empty; FSM in IDLE.
  - b1 = 0, b2 = 0, drv_valid = 0, model_q = 0, err = 0, err_cnt = 0, busy = 0, tgt_ready = 1.
  - model_q = 0 matches the flop's power-up state of 0.
  - A reset asserted mid-operation discards queued and in-flight targets immediately.
- FIFO:
  - Push on tgt_valid && tgt_ready.
  - No push when full, even if a pop occurs in the same cycle.
  - Simultaneous push and pop is legal when not full; occupancy is then unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: moves to DRIVE when the FIFO is non-empty.
  - DRIVE (1 cycle):
    - Pop the head entry as tgt.
    - Register controls: MODE_POLICY = 0 gives b2 = 1, b1 = tgt; MODE_POLICY = 1 gives b2 = 0, b1 = tgt ^ model_q.
    - Set drv_valid = 1, latch expected exp = tgt, go to WAIT.
  - WAIT (1 cycle):
    - The flop samples the controls on this cycle's rising edge.
    - Controls return to hold: b1 = 0, b2 = 0, drv_valid = 0. Go to CHECK.
  - CHECK (1 cycle):
    - Compare q_fb with exp.
    - On mismatch: err <= 1 and err_cnt++, saturating at all-ones.
    - model_q <= q_fb in all cases, so the model resyncs to the real flop.
    - Go to DRIVE if the FIFO is non-empty, else IDLE.
- Timing:
  - Latency from push to control: at least 1 cycle (IDLE to DRIVE on the cycle after the first push).
  - Throughput is one target per 3 cycles.
- Hold encoding (b1 = 0, b2 = 0, toggle with 0) is driven whenever drv_valid = 0, so the flop never changes outside a drive.
- A target equal to model_q is still driven and checked; in toggle policy this is b1 = 0.
- err clears only on reset.

Optional Feature:
- Macro: DTE_TRACE_EN.
- When defined: on every CHECK cycle, a simulation-only $display prints time, exp, q_fb, model_q and a MATCH or MISMATCH tag.
- When undefined: no display code is compiled; RTL behaviour is identical.

Test Plan:
- Reset, then push 1 with MODE_POLICY = 0 → DRIVE cycle shows b2 = 1, b1 = 1, drv_valid = 1; in CHECK, q_fb = 1 gives model_q = 1, err = 0.
- MODE_POLICY = 1, push 1,1,0 from model 0 → b1 sequence 1,0,1 with b2 = 0 each time; final model_q = 0; 9 cycles from first DRIVE to last CHECK.
- Fill the FIFO with 4 entries while the FSM is stalled → tgt_ready = 0; a 5th push is ignored; all 4 targets drive in order.
- Force q_fb = 0 when exp = 1 → err = 1, err_cnt = 1, model_q = 0; next target 1 in toggle policy drives b1 = 1.
- CNT_W = 2 with 5 forced mismatches → err_cnt stops at 3.
- Assert rst_n low during WAIT → all outputs return to reset values at once; the FIFO is empty and the FSM resumes in IDLE after release.

Source files
------------

// File: rtl/dt_ff_excitation_gen.sv
// dt_ff_excitation_gen
// Converts a stream of target state bits into load/toggle flop controls
// (b1 = data/toggle, b2 = mode: 1 load, 0 toggle/hold), keeps a model of
// the flop state and checks the flop's fed-back output after each drive.
// Optional: define DTE_TRACE_EN for a simulation-only trace of every check.
module dt_ff_excitation_gen #(
  parameter int DEPTH       = 4,
  parameter int MODE_POLICY = 0,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  input  logic             tgt_bit,
  output logic             tgt_ready,
  output logic             b1,
  output logic             b2,
  output logic             drv_valid,
  input  logic             q_fb,
  output logic             busy,
  output logic             model_q,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_CHECK = 2'd3;

  logic [1:0]    state;
  logic          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          head;
  logic          exp_bit;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign push      = tgt_valid && !full;
  assign pop       = (state == S_DRIVE);
  assign head      = mem[rd_ptr];
  assign tgt_ready = !full;
  assign busy      = !empty || (state != S_IDLE);

  // FIFO storage: written on accepted pushes, never reset
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= tgt_bit;
  end

  // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is a power of two)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Drive/wait/check sequencer; controls default to the hold encoding every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      b1        <= 1'b0;
      b2        <= 1'b0;
      drv_valid <= 1'b0;
      exp_bit   <= 1'b0;
      model_q   <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      b1        <= 1'b0;
      b2        <= 1'b0;
      drv_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!empty)
            state <= S_DRIVE;
        end
        S_DRIVE: begin
          drv_valid <= 1'b1;
          exp_bit   <= head;
          if (MODE_POLICY == 0) begin
            b2 <= 1'b1;
            b1 <= head;
          end else begin
            b2 <= 1'b0;
            b1 <= head ^ model_q;
          end
          state <= S_WAIT;
        end
        S_WAIT: begin
          state <= S_CHECK;
        end
        S_CHECK: begin
          if (q_fb != exp_bit) begin
            err <= 1'b1;
            if (err_cnt != '1)
              err_cnt <= err_cnt + CNT_W'(1);
          end
          model_q <= q_fb;
          state   <= empty ? S_IDLE : S_DRIVE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DTE_TRACE_EN
  // Simulation-only trace of each check
  always_ff @(posedge clk) begin
    if (rst_n && state == S_CHECK)
      $display("[%0t] dte check exp=%0b q_fb=%0b model_q=%0b %s", $time, exp_bit, q_fb,
               model_q, (q_fb == exp_bit) ? "MATCH" : "MISMATCH");
  end
`endif

endmodule

// File: tb/tb_dt_ff_excitation_gen.sv
// Scoreboard bench for dt_ff_excitation_gen: one load-policy instance
// (CNT_W = 2) and one toggle-policy instance, each closed around a
// behavioural load/toggle flop that can be told to ignore a drive.
module tb_dt_ff_excitation_gen;

  localparam int CW0 = 2;
  localparam int CW1 = 8;

  typedef struct {
    int dut;
    bit eb1;
    bit eb2;
    bit emq;
    bit eer;
    int ecnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] tgt_valid = '0;
  logic [1:0] tgt_bit = '0;
  logic [1:0] tgt_ready, b1, b2, drv_valid, busy, model_q, err, q_fb;
  logic [CW0-1:0] cnt0;
  logic [CW1-1:0] cnt1;
  logic fq0, fq1;
  bit   skip0, skip1;
  bit   mute = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  bit   stuck0[$];
  bit   stuck1[$];
  int   drv_log[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign q_fb = {fq1, fq0};

  dt_ff_excitation_gen #(.DEPTH(4), .MODE_POLICY(0), .CNT_W(CW0)) u_load (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid[0]), .tgt_bit(tgt_bit[0]),
    .tgt_ready(tgt_ready[0]), .b1(b1[0]), .b2(b2[0]), .drv_valid(drv_valid[0]),
    .q_fb(q_fb[0]), .busy(busy[0]), .model_q(model_q[0]), .err(err[0]), .err_cnt(cnt0)
  );

  dt_ff_excitation_gen #(.DEPTH(4), .MODE_POLICY(1), .CNT_W(CW1)) u_tog (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid[1]), .tgt_bit(tgt_bit[1]),
    .tgt_ready(tgt_ready[1]), .b1(b1[1]), .b2(b2[1]), .drv_valid(drv_valid[1]),
    .q_fb(q_fb[1]), .busy(busy[1]), .model_q(model_q[1]), .err(err[1]), .err_cnt(cnt1)
  );

  // Behavioural flops: load when b2, else toggle by b1; a stuck drive is ignored
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) fq0 <= 1'b0;
    else begin
      skip0 = 1'b0;
      if (drv_valid[0] && stuck0.size() > 0) skip0 = stuck0.pop_front();
      if (!skip0) fq0 <= b2[0] ? b1[0] : (fq0 ^ b1[0]);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) fq1 <= 1'b0;
    else begin
      skip1 = 1'b0;
      if (drv_valid[1] && stuck1.size() > 0) skip1 = stuck1.pop_front();
      if (!skip1) fq1 <= b2[1] ? b1[1] : (fq1 ^ b1[1]);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int g);
    return (g == 0) ? 32'(cnt0) : 32'(cnt1);
  endfunction

  // Monitor: pops an expectation on each drive, checks controls, then the check outcome
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && !mute) begin
        for (int g = 0; g < 2; g++) begin
          if (drv_valid[g]) begin
            if (sb.size() == 0) begin
              check($sformatf("dut%0d_unexpected_drive", g), 32'(drv_valid[g]), 0);
            end else begin
              e = sb.pop_front();
              check($sformatf("dut%0d_drive_owner", g), g, e.dut);
              check($sformatf("dut%0d_b1", g), 32'(b1[g]), 32'(e.eb1));
              check($sformatf("dut%0d_b2", g), 32'(b2[g]), 32'(e.eb2));
              if (g == 1) drv_log.push_back(cyc);
              repeat (2) @(negedge clk);
              check($sformatf("dut%0d_model_q", g), 32'(model_q[g]), 32'(e.emq));
              check($sformatf("dut%0d_err", g), 32'(err[g]), 32'(e.eer));
              check($sformatf("dut%0d_err_cnt", g), cnt_of(g), e.ecnt);
            end
          end
        end
      end
    end
  end

  task automatic push(input int g, input bit t, input bit stk, input bit eb1, input bit eb2,
                      input bit emq, input bit eer, input int ecnt);
    exp_t e;
    int n;
    e = '{dut: g, eb1: eb1, eb2: eb2, emq: emq, eer: eer, ecnt: ecnt};
    sb.push_back(e);
    if (g == 0) stuck0.push_back(stk); else stuck1.push_back(stk);
    n = 0;
    while (!tgt_ready[g] && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check($sformatf("dut%0d_push_ready_timeout", g), 32'(tgt_ready[g]), 1);
    tgt_valid[g] = 1'b1;
    tgt_bit[g]   = t;
    @(negedge clk);
    tgt_valid[g] = 1'b0;
  endtask

  task automatic drain(input int g);
    int n;
    n = 0;
    while ((busy[g] || sb.size() > 0) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) check($sformatf("dut%0d_drain_timeout", g), 32'(busy[g]), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_state(input int g, input string tag);
    check($sformatf("%s_dut%0d_b1", tag, g), 32'(b1[g]), 0);
    check($sformatf("%s_dut%0d_b2", tag, g), 32'(b2[g]), 0);
    check($sformatf("%s_dut%0d_drv_valid", tag, g), 32'(drv_valid[g]), 0);
    check($sformatf("%s_dut%0d_model_q", tag, g), 32'(model_q[g]), 0);
    check($sformatf("%s_dut%0d_err", tag, g), 32'(err[g]), 0);
    check($sformatf("%s_dut%0d_err_cnt", tag, g), cnt_of(g), 0);
    check($sformatf("%s_dut%0d_busy", tag, g), 32'(busy[g]), 0);
    check($sformatf("%s_dut%0d_tgt_ready", tag, g), 32'(tgt_ready[g]), 1);
  endtask

  initial begin : watchdog
    #300000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : stimulus
    int n;
    int seen;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) check_reset_state(g, "por");
    rst_n = 1'b1;
    @(negedge clk);

    // Load policy: single target 1
    push(0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    drain(0);

    // Load policy: back-to-back pushes fill the FIFO; a push while full is dropped
    push(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    push(0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    push(0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    push(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    push(0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    check("full_tgt_ready", 32'(tgt_ready[0]), 0);
    check("full_busy", 32'(busy[0]), 1);
    tgt_valid[0] = 1'b1;
    tgt_bit[0]   = 1'b0;
    @(negedge clk);
    tgt_valid[0] = 1'b0;
    check("after_pop_tgt_ready", 32'(tgt_ready[0]), 1);
    drain(0);

    // Load policy, 2-bit counter: five ignored drives of 0 against a flop at 1
    push(0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1);
    push(0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2);
    push(0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3);
    push(0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3);
    push(0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3);
    drain(0);

    // Toggle policy: 1,1,0 from model 0 -> b1 1,0,1
    drv_log.delete();
    push(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    push(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    push(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    drain(1);
    check("toggle_drive_count", drv_log.size(), 3);
    if (drv_log.size() == 3)
      check("toggle_drive_span", drv_log[2] - drv_log[0], 6);

    // Toggle policy: ignored drive -> mismatch, then resync and drive again
    push(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1);
    push(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    // Target equal to model is still driven, toggle with 0
    push(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    drain(1);

    // Reset while the toggle instance is in WAIT with another target queued
    mute = 1'b1;
    tgt_valid[1] = 1'b1;
    tgt_bit[1]   = 1'b0;
    @(negedge clk);
    tgt_bit[1]   = 1'b1;
    @(negedge clk);
    tgt_valid[1] = 1'b0;
    n = 0;
    while (!drv_valid[1] && n < 20) begin @(negedge clk); n++; end
    check("pre_reset_drv_valid", 32'(drv_valid[1]), 1);
    check("pre_reset_b1", 32'(b1[1]), 1);
    rst_n = 1'b0;
    #1;
    check_reset_state(1, "midrst");
    check_reset_state(0, "midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_busy", 32'(busy[1]), 0);
    check("post_reset_tgt_ready", 32'(tgt_ready[1]), 1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen += 32'(drv_valid[1]);
    end
    check("post_reset_no_drive", seen, 0);
    mute = 1'b0;
    push(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    drain(1);

    check("scoreboard_leftover", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
